// File: rtl/rbus_intmem_pkg.sv
// Shared encodings for the rbus internal memory responder.
package rbus_intmem_pkg;

  // Request modes carried in header bits [1:0].
  typedef enum logic [1:0] {
    ModeRd1 = 2'b00,
    ModeRd8 = 2'b01,
    ModeWr  = 2'b10,
    ModeUpd = 2'b11
  } mode_e;

  // Header field positions.
  localparam int unsigned HdrModeLsb = 0;
  localparam int unsigned HdrAddrLsb = 3;
  localparam int unsigned HdrAddrMsb = 38;
  localparam int unsigned HdrLenBit  = 39;
  localparam int unsigned HdrTagLsb  = 40;
  localparam int unsigned HdrTagMsb  = 69;

  // Data word byte-enable field.
  localparam int unsigned DatBeLsb = 64;

  // Type code placed in the top bits of every response header.
  localparam logic [1:0] RspType = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWdat,
    StRstart,
    StRbusy
  } state_e;

endpackage

// File: rtl/rbus_dffs.sv
// rbus input stage: small word FIFO with 1-word and 9-word credit flags.
module rbus_dffs #(
  parameter int unsigned DEPTH_LOG2 = 4  // must be >= 4 so a 9-word packet fits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_stb,
  input  logic        in_sof,
  input  logic [71:0] in_data,
  output logic [1:0]  rdy,
  input  logic        pop,
  output logic        head_vld,
  output logic        head_sof,
  output logic [71:0] head_data
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [72:0]           mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  push, take;

  assign push      = in_stb && (cnt_q != CW'(Depth));
  assign take      = pop && (cnt_q != '0);
  assign rdy[0]    = cnt_q < CW'(Depth);
  assign rdy[1]    = cnt_q <= CW'(Depth - 9);
  assign head_vld  = cnt_q != '0;
  assign head_sof  = mem[rptr_q][72];
  assign head_data = mem[rptr_q][71:0];

  // Pointer and occupancy tracking; reset empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (take) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(take);
    end
  end

  // Word storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {in_sof, in_data};
  end

endmodule

// File: rtl/rbus_intmem_ram.sv
// Simple dual-port 64-bit RAM: byte-enabled write, registered read.
module rbus_intmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wbe,
  input  logic [63:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [2**DEPTH_LOG2];

  // Byte-masked write and one-cycle registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rbus_intmem.sv
// rbus internal memory responder: rd1 / rd8 / wr / upd over a byte-enabled RAM.
module rbus_intmem
  import rbus_intmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter bit          WRITABLE   = 1'b1,
  parameter int unsigned GAP        = 11,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_sof,
  input  logic [71:0] i_data,
  output logic [1:0]  i_rdy,
  output logic        o_stb,
  output logic        o_sof,
  output logic [71:0] o_data,
  input  logic [1:0]  o_rdy
);

  localparam int unsigned AW = DEPTH_LOG2;

  logic          hv, hs, pop;
  logic [71:0]   hd;
  state_e        state_q;
  logic [71:0]   hdr_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] waddr_q;
  logic [4:0]    gap_q;
  logic [3:0]    seq_q;
  logic          rsp_n8_q;
  logic [AW-1:0] rsp_base_q;
  logic [3:0]    seq_last;
  logic          hdr_n8, fire, we;
  logic [AW-1:0] raddr;
  logic [63:0]   rdata;
  mode_e         head_mode, hdr_mode;
  logic          unused_hdr;

  rbus_dffs #(
    .DEPTH_LOG2(4)
  ) u_dffs (
    .clk      (clk),
    .rst      (rst),
    .in_stb   (i_stb),
    .in_sof   (i_sof),
    .in_data  (i_data),
    .rdy      (i_rdy),
    .pop      (pop),
    .head_vld (hv),
    .head_sof (hs),
    .head_data(hd)
  );

  rbus_intmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr_q),
    .wbe  (hd[DatBeLsb +: 8]),
    .wdata(hd[63:0]),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign head_mode  = mode_e'(hd[HdrModeLsb +: 2]);
  assign hdr_mode   = mode_e'(hdr_q[HdrModeLsb +: 2]);
  assign hdr_n8     = (hdr_mode == ModeRd8) || (hdr_mode == ModeUpd && hdr_q[HdrLenBit]);
  assign fire       = (state_q == StRstart) && (gap_q == '0) && (hdr_n8 ? o_rdy[1] : o_rdy[0]);
  assign we         = WRITABLE && (state_q == StWdat) && hv && !hs;
  assign seq_last   = rsp_n8_q ? 4'd10 : 4'd3;
  assign raddr      = rsp_base_q + AW'(seq_q - 4'd2);
  assign unused_hdr = ^hdr_q[71:70];

  // Pop every word in IDLE (stray payload is dropped), payload only in WDAT.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:   pop = hv;
      StWdat:   pop = hv && !hs;
      StRstart: pop = 1'b0;
      StRbusy:  pop = 1'b0;
    endcase
  end

  // Request FSM and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      gap_q   <= '0;
    end else begin
      if (gap_q != '0) gap_q <= gap_q - 5'd1;
      unique case (state_q)
        StIdle: begin
          if (hv && hs) begin
            hdr_q   <= hd;
            waddr_q <= hd[HdrAddrLsb +: AW];
            cnt_q   <= hd[HdrLenBit] ? 4'd8 : 4'd1;
            state_q <= (head_mode == ModeWr || head_mode == ModeUpd) ? StWdat : StRstart;
          end
        end
        StWdat: begin
          if (hv) begin
            if (hs) begin
              // Short packet: leave the next header in the stage.
              state_q <= (hdr_mode == ModeUpd) ? StRstart : StIdle;
            end else begin
              waddr_q <= waddr_q + 1'b1;
              cnt_q   <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_q <= (hdr_mode == ModeUpd) ? StRstart : StIdle;
            end
          end
        end
        StRstart: begin
          if (fire) begin
            gap_q   <= 5'(GAP - 1);
            state_q <= StRbusy;
          end
        end
        StRbusy: begin
          // Hand back two cycles early so the next pop and RSTART land on gap expiry.
          if (gap_q <= 5'd2) state_q <= StIdle;
        end
      endcase
    end
  end

  // Response sequencer: header at fire+3, data words follow back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      rsp_n8_q   <= 1'b0;
      rsp_base_q <= '0;
      o_stb      <= 1'b0;
      o_sof      <= 1'b0;
      o_data     <= '0;
    end else begin
      o_stb <= 1'b0;
      o_sof <= 1'b0;
      if (fire) begin
        seq_q      <= 4'd1;
        rsp_n8_q   <= hdr_n8;
        rsp_base_q <= hdr_q[HdrAddrLsb +: AW];
      end else if (seq_q != 4'd0 && seq_q != seq_last) begin
        seq_q <= seq_q + 4'd1;
      end else begin
        seq_q <= 4'd0;
      end
      if (seq_q == 4'd2) begin
        o_stb  <= 1'b1;
        o_sof  <= 1'b1;
        o_data <= {RspType, hdr_q[HdrTagMsb:HdrTagLsb], rsp_n8_q, hdr_q[HdrAddrMsb:0]};
      end else if (seq_q > 4'd2) begin
        o_stb  <= 1'b1;
        o_data <= {8'hFF, rdata};
      end
    end
  end

endmodule
